// File: rtl/display_scan_if.sv
// Bundles the scan controller's control inputs and display-side outputs.
// master: the side that drives en/digit_en (system or bench).
// slave:  the scan controller itself.
interface display_scan_if;
  logic       en;
  logic [3:0] digit_en;
  logic [1:0] sel;
  logic [3:0] an_n;
  logic       blank;
  logic       tick;

  modport master (output en, output digit_en,
                  input  sel, input an_n, input blank, input tick);
  modport slave  (input  en, input digit_en,
                  output sel, output an_n, output blank, output tick);
endinterface

// File: rtl/display_scan_ctrl.sv
// Time-multiplexed scan controller for a 4-digit display.
// Drives the nibble-mux select, active-low digit enables, a blank flag and an
// advance tick. Masked digits are skipped.
// Optional feature macro: SCAN_BLANK_EN inserts BLANK_CYCLES dark cycles after
// every digit advance (anti-ghosting). Default build has no BLANK state.
module display_scan_ctrl #(
  parameter int DIV_WIDTH    = 16,
  parameter int DIV_MAX      = 49999,
  parameter int BLANK_CYCLES = 4
) (
  input  logic           clk,
  input  logic           rst,
  display_scan_if.slave  bus
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHOW  = 2'd1;
`ifdef SCAN_BLANK_EN
  localparam logic [1:0] S_BLANK = 2'd2;
  localparam logic [DIV_WIDTH-1:0] BLANK_LAST = DIV_WIDTH'(BLANK_CYCLES - 1);
`endif
  localparam logic [DIV_WIDTH-1:0] CNT_MAX = DIV_WIDTH'(DIV_MAX);

  logic [1:0]           state_q, state_d;
  logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
  logic [1:0]           sel_q, sel_d;
  logic [3:0]           an_n_q, an_n_d;
  logic                 blank_q, blank_d;
  logic                 tick_q, tick_d;
  logic [1:0]           nxt_sel;

  // First enabled digit after cur in scan order; wraps back to cur itself.
  function automatic logic [1:0] next_enabled(input logic [1:0] cur,
                                              input logic [3:0] mask);
    logic [1:0] cand;
    logic       found;
    next_enabled = cur;
    found        = 1'b0;
    for (int k = 1; k < 4; k++) begin
      cand = cur + 2'(k);
      if (!found && mask[cand]) begin
        next_enabled = cand;
        found        = 1'b1;
      end
    end
  endfunction

  assign nxt_sel = next_enabled(sel_q, bus.digit_en);

  // Next-state logic; outputs are derived from the next state so they are registered.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    tick_d  = 1'b0;
    if (!bus.en || bus.digit_en == 4'b0000) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          state_d = S_SHOW;
          cnt_d   = '0;
          if (!bus.digit_en[sel_q]) sel_d = nxt_sel;
        end
        S_SHOW: begin
          // A digit masked off while lit is abandoned at once.
          if (!bus.digit_en[sel_q] || cnt_q == CNT_MAX) begin
            cnt_d  = '0;
            sel_d  = nxt_sel;
            tick_d = 1'b1;
`ifdef SCAN_BLANK_EN
            state_d = S_BLANK;
`endif
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
`ifdef SCAN_BLANK_EN
        S_BLANK: begin
          if (cnt_q == BLANK_LAST) begin
            state_d = S_SHOW;
            cnt_d   = '0;
            // The mask may have changed during the gap; never light a masked digit.
            if (!bus.digit_en[sel_q]) sel_d = nxt_sel;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
`endif
        default: begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
    an_n_d  = (state_d == S_SHOW) ? ~(4'b0001 << sel_d) : 4'b1111;
    blank_d = (state_d != S_SHOW);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      sel_q   <= 2'd0;
      an_n_q  <= 4'b1111;
      blank_q <= 1'b1;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      an_n_q  <= an_n_d;
      blank_q <= blank_d;
      tick_q  <= tick_d;
    end
  end

  assign bus.sel   = sel_q;
  assign bus.an_n  = an_n_q;
  assign bus.blank = blank_q;
  assign bus.tick  = tick_q;

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Self-checking bench for display_scan_ctrl (DIV_MAX=3, BLANK_CYCLES=2).
// A dwell-time model predicts sel/an_n/blank/tick every cycle; directed
// literal checks pin the model on the key scenarios; then random traffic.
module tb_display_scan_ctrl;
  localparam int DIV_MAX = 3;
  localparam int BLANK_CYCLES = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;

  display_scan_if bus ();

  display_scan_ctrl #(.DIV_WIDTH(4), .DIV_MAX(DIV_MAX), .BLANK_CYCLES(BLANK_CYCLES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // mode: 0 dark (idle), 1 lit, 2 anti-ghost gap
  int       m_mode  = 0;
  int       m_sel   = 0;
  int       m_shown = 0;   // cycles the current digit has been lit, including this one
  int       m_gap   = 0;   // gap cycles elapsed, including this one
  bit       m_tick  = 0;
  bit       m_blank_en;

  function automatic int nxt(input int s, input logic [3:0] m);
    for (int k = 1; k <= 4; k++)
      if (m[(s + k) % 4]) return (s + k) % 4;
    return s;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
`ifdef SCAN_BLANK_EN
    m_blank_en = 1'b1;
`else
    m_blank_en = 1'b0;
`endif
  end

  always @(posedge clk) begin
    m_tick = 0;
    if (rst) begin
      m_mode = 0; m_sel = 0;
    end else if (!bus.en || bus.digit_en == 4'b0000) begin
      m_mode = 0;
    end else if (m_mode == 0) begin
      m_mode = 1; m_shown = 1;
      if (!bus.digit_en[m_sel]) m_sel = nxt(m_sel, bus.digit_en);
    end else if (m_mode == 1) begin
      if (!bus.digit_en[m_sel] || m_shown == DIV_MAX + 1) begin
        m_sel = nxt(m_sel, bus.digit_en);
        m_tick = 1;
        if (m_blank_en) begin m_mode = 2; m_gap = 1; end
        else m_shown = 1;
      end else m_shown++;
    end else begin
      if (m_gap == BLANK_CYCLES) begin
        m_mode = 1; m_shown = 1;
        if (!bus.digit_en[m_sel]) m_sel = nxt(m_sel, bus.digit_en);
      end else m_gap++;
    end
    #1;
    chk("sel",   int'(bus.sel),   m_sel);
    chk("an_n",  int'(bus.an_n),  (m_mode == 1) ? int'(~(4'b0001 << m_sel) & 4'hF) : 4'hF);
    chk("blank", int'(bus.blank), (m_mode == 1) ? 0 : 1);
    chk("tick",  int'(bus.tick),  int'(m_tick));
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_sel2_lit();
    int n = 0;
    while (!(bus.sel == 2'd2 && bus.blank == 1'b0) && n < 100) begin
      step(1); n++;
    end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL wait_sel2: sel=%0d blank=%0b never reached sel 2 lit", bus.sel, bus.blank);
    end
  endtask

  initial begin
    bus.en = 1'b0;
    bus.digit_en = 4'b1111;
    // reset
    step(2);
    rst = 1'b0;
    chk("rst_sel", int'(bus.sel), 0);
    chk("rst_an_n", int'(bus.an_n), 4'hF);
    chk("rst_blank", int'(bus.blank), 1);
    chk("rst_tick", int'(bus.tick), 0);

    // full scan
    bus.en = 1'b1;
    step(1);
    chk("scan_first_an", int'(bus.an_n), 4'b1110);
    chk("scan_first_tick", int'(bus.tick), 0);
    step(3);
    chk("scan_hold_an", int'(bus.an_n), 4'b1110);
    step(1);
    chk("scan_adv_tick", int'(bus.tick), 1);
    chk("scan_adv_sel", int'(bus.sel), 1);
`ifdef SCAN_BLANK_EN
    chk("scan_gap_an", int'(bus.an_n), 4'hF);
    step(1);
    chk("scan_gap2_blank", int'(bus.blank), 1);
    step(1);
    chk("scan_after_gap_an", int'(bus.an_n), 4'b1101);
`else
    chk("scan_adv_an", int'(bus.an_n), 4'b1101);
`endif
    step(30);

    // mask 0101: digits 1 and 3 never lit
    bus.digit_en = 4'b0101;
    step(1);
    for (int i = 0; i < 24; i++) begin
      chk("mask_d1_dark", int'(bus.an_n[1]), 1);
      chk("mask_d3_dark", int'(bus.an_n[3]), 1);
      step(1);
    end

    // clear the lit digit 2 -> immediate advance
    bus.digit_en = 4'b1111;
    wait_sel2_lit();
    bus.digit_en = 4'b1011;
    step(1);
    chk("drop_sel", int'(bus.sel), 3);
    chk("drop_tick", int'(bus.tick), 1);
`ifdef SCAN_BLANK_EN
    chk("drop_an", int'(bus.an_n), 4'hF);
`else
    chk("drop_an", int'(bus.an_n), 4'b0111);
`endif
    step(10);

    // en drop mid-scan keeps sel, resume on same digit
    bus.digit_en = 4'b1111;
    wait_sel2_lit();
    bus.en = 1'b0;
    step(1);
    chk("off_sel", int'(bus.sel), 2);
    chk("off_an", int'(bus.an_n), 4'hF);
    chk("off_tick", int'(bus.tick), 0);
    bus.en = 1'b1;
    step(1);
    chk("resume_an", int'(bus.an_n), 4'b1011);
    step(2);
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    chk("midrst_sel", int'(bus.sel), 0);
    chk("midrst_an", int'(bus.an_n), 4'hF);
    chk("midrst_blank", int'(bus.blank), 1);

    // single enabled digit: continuous display, periodic tick
    bus.digit_en = 4'b1000;
    step(40);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(0, 299) == 0);
      bus.en = ($urandom_range(0, 24) != 0);
      if ($urandom_range(0, 11) == 0) bus.digit_en = 4'($urandom_range(0, 15));
      step(1);
    end
    rst = 1'b0;
    step(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
